// File: rtl/mux_rr_pipe.sv
// N-to-1 multiplexer with fixed-select or round-robin arbitration,
// followed by one valid/ready output register stage.
module mux_rr_pipe #(
   parameter int WIDTH = 28,
   parameter int N     = 3,
   parameter int SELW  = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic [SELW-1:0]      sel,
   input  logic                 mode,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      out_src
);

   // Handshake: a word moves on any rising edge where valid and ready are
   // both high; valid never depends on ready, and ready is granted only
   // while the output register is empty or being drained this cycle.

   logic [SELW-1:0]  ptr;
   logic             reg_free;

   logic             fix_hit;
   logic [SELW-1:0]  fix_idx;
   logic             hi_hit;
   logic [SELW-1:0]  hi_idx;
   logic             lo_hit;
   logic [SELW-1:0]  lo_idx;
   logic             rr_hit;
   logic [SELW-1:0]  rr_idx;

   logic             gnt_hit;
   logic [SELW-1:0]  gnt_idx;
   logic [WIDTH-1:0] gnt_data;
   logic [SELW-1:0]  ptr_next;

   assign reg_free = !out_valid || out_ready;

   // Fixed select; an out-of-range sel matches no channel and grants nothing.
   always_comb begin
      fix_hit = 1'b0;
      fix_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (sel == SELW'(i) && in_valid[i]) begin
            fix_hit = 1'b1;
            fix_idx = SELW'(i);
         end
      end
   end

   // Round-robin: lowest valid channel at or above ptr, else wrap to the
   // lowest valid channel overall (which is then necessarily below ptr).
   always_comb begin
      hi_hit = 1'b0;
      hi_idx = '0;
      lo_hit = 1'b0;
      lo_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            lo_hit = 1'b1;
            lo_idx = SELW'(i);
            if (SELW'(i) >= ptr) begin
               hi_hit = 1'b1;
               hi_idx = SELW'(i);
            end
         end
      end
   end

   assign rr_hit = hi_hit || lo_hit;
   assign rr_idx = hi_hit ? hi_idx : lo_idx;

   assign gnt_hit = !reset && reg_free && (mode ? rr_hit : fix_hit);
   assign gnt_idx = mode ? rr_idx : fix_idx;

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         in_ready[i] = gnt_hit && (gnt_idx == SELW'(i));
      end
   end

   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_idx == SELW'(i)) begin
            gnt_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign ptr_next = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);

   // Output register: load on grant, otherwise clear valid when drained.
   // Data and source hold after a drain so the last word stays observable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
      end else if (gnt_hit) begin
         out_valid <= 1'b1;
         out_data  <= gnt_data;
         out_src   <= gnt_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Pointer only advances on round-robin grants.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (gnt_hit && mode) begin
         ptr <= ptr_next;
      end
   end

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Self-checking bench for mux_rr_pipe: directed scenarios plus randomized
// traffic against a rule-level reference model and an expected-word queue.
module tb_mux_rr_pipe;

   localparam int WIDTH = 28;
   localparam int N     = 3;
   localparam int SELW  = 2;

   logic                clk = 1'b0;
   logic                reset;
   logic [N*WIDTH-1:0]  in_data;
   logic [N-1:0]        in_valid;
   logic [N-1:0]        in_ready;
   logic [SELW-1:0]     sel;
   logic                mode;
   logic [WIDTH-1:0]    out_data;
   logic                out_valid;
   logic                out_ready;
   logic [SELW-1:0]     out_src;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   bit               m_valid;
   logic [WIDTH-1:0] m_data;
   int               m_src;
   int               m_ptr;
   logic [WIDTH-1:0] exp_q[$];

   mux_rr_pipe #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .mode      (mode),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_src   (out_src)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int model_grant();
      int g;
      g = -1;
      if (mode == 1'b0) begin
         if (int'(sel) < N && in_valid[sel]) g = int'(sel);
      end else begin
         for (int k = N - 1; k >= 0; k--) begin
            if (in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
      end
      return g;
   endfunction

   function automatic logic [N-1:0] model_ready();
      logic [N-1:0] r;
      int g;
      r = '0;
      g = model_grant();
      if (!reset && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   task automatic model_edge();
      int g;
      g = model_grant();
      if ((!m_valid || out_ready) && g >= 0) begin
         m_data  = in_data[g*WIDTH +: WIDTH];
         m_src   = g;
         m_valid = 1'b1;
         exp_q.push_back(m_data);
         if (mode) m_ptr = (g + 1) % N;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_ptr   = 0;
      exp_q.delete();
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      if (!reset) model_edge();
      @(negedge clk);
   endtask

   task automatic sync_queue();
      exp_q.delete();
      if (m_valid) exp_q.push_back(m_data);
   endtask

   task automatic random_data();
      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1; mode = 1'b1; sel = '0; in_valid = '1; out_ready = 1'b1;
      in_data = '1;
      model_reset();
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
      n_cmp++; if (out_src !== '0) begin n_fail++; $display("FAIL reset_out_src got %0d want 0", out_src); end
      n_cmp++; if (in_ready !== '0) begin n_fail++; $display("FAIL reset_in_ready got %b want 000", in_ready); end
      repeat (2) tick();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== '0) begin
         n_fail++; $display("FAIL reset_held out_valid=%b in_ready=%b want 0/000", out_valid, in_ready);
      end
      in_valid = '0;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_fixed_select();
      logic [WIDTH-1:0] exp_d[3];
      int               sels[3];
      exp_d[0] = 28'h19F; exp_d[1] = 28'h111; exp_d[2] = 28'h035;
      sels[0] = 1; sels[1] = 2; sels[2] = 0;
      mode = 1'b0; out_ready = 1'b1; in_valid = '1;
      in_data = {28'h111, 28'h19F, 28'h035};
      for (int k = 0; k < 3; k++) begin
         sel = SELW'(sels[k]);
         #1;
         n_cmp++; if (in_ready !== (3'b001 << sels[k])) begin
            n_fail++; $display("FAIL fixed_ready sel=%0d got %b want %b", sels[k], in_ready, 3'b001 << sels[k]);
         end
         tick();
         n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_src !== SELW'(sels[k])) begin
            n_fail++; $display("FAIL fixed_out sel=%0d got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                               sels[k], out_valid, out_data, out_src, exp_d[k], sels[k]);
         end
      end
   endtask

   task automatic test_invalid_select();
      in_valid = '0; out_ready = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got v=%b want 0", out_valid); end
      n_cmp++; if (out_data !== 28'h035 || out_src !== 2'd0) begin
         n_fail++; $display("FAIL drain_hold got d=%h s=%0d want d=035 s=0", out_data, out_src);
      end
      mode = 1'b0; sel = 2'd3; in_valid = '1;
      #1;
      n_cmp++; if (in_ready !== '0) begin n_fail++; $display("FAIL invalid_sel_ready got %b want 000", in_ready); end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL invalid_sel_valid cyc=%0d got %b want 0", k, out_valid); end
      end
   endtask

   task automatic test_round_robin();
      mode = 1'b1; in_valid = '1; out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         random_data();
         #1;
         tick();
         n_cmp++; if (out_valid !== 1'b1 || out_src !== SELW'(k % 3) || out_data !== m_data) begin
            n_fail++; $display("FAIL rr_seq k=%0d got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                               k, out_valid, out_src, out_data, k % 3, m_data);
         end
      end
   endtask

   task automatic test_rr_skip();
      int exp_s[4];
      exp_s[0] = 0; exp_s[1] = 2; exp_s[2] = 0; exp_s[3] = 2;
      mode = 1'b1; in_valid = 3'b101; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         random_data();
         #1;
         tick();
         n_cmp++; if (out_src !== SELW'(exp_s[k]) || out_data !== m_data) begin
            n_fail++; $display("FAIL rr_skip k=%0d got s=%0d d=%h want s=%0d d=%h", k, out_src, out_data, exp_s[k], m_data);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] held;
      mode = 1'b1; in_valid = '1; out_ready = 1'b1;
      random_data();
      tick();
      sync_queue();
      held = out_data;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         random_data();
         #1;
         n_cmp++; if (in_ready !== '0) begin n_fail++; $display("FAIL bp_ready k=%0d got %b want 000", k, in_ready); end
         tick();
         n_cmp++; if (out_valid !== 1'b1 || out_data !== held) begin
            n_fail++; $display("FAIL bp_hold k=%0d got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, held);
         end
      end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== model_ready()) begin n_fail++; $display("FAIL bp_release_ready got %b want %b", in_ready, model_ready()); end
      n_cmp++; if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
         n_fail++; $display("FAIL bp_drain_word got %h want held word", out_data);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      tick();
      n_cmp++; if (out_valid !== 1'b1 || exp_q.size() != 1 || out_data !== exp_q[0] || out_src !== SELW'(m_src)) begin
         n_fail++; $display("FAIL bp_next_word got v=%b d=%h s=%0d want v=1 d=%h s=%0d", out_valid, out_data, out_src, m_data, m_src);
      end
   endtask

   task automatic test_reset_mid_stream();
      mode = 1'b1; in_valid = '1; out_ready = 1'b1;
      repeat (2) begin random_data(); tick(); end
      #2 reset = 1'b1;
      #1;
      model_reset();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== '0 || out_src !== '0 || out_data !== '0) begin
         n_fail++; $display("FAIL mid_reset got v=%b r=%b s=%0d d=%h want 0", out_valid, in_ready, out_src, out_data);
      end
      @(negedge clk);
      reset = 1'b0;
      in_valid = 3'b110;
      random_data();
      #1;
      n_cmp++; if (in_ready !== 3'b010) begin n_fail++; $display("FAIL post_reset_ready got %b want 010", in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== in_data[WIDTH +: WIDTH]) begin
         n_fail++; $display("FAIL post_reset_grant got v=%b s=%0d d=%h want v=1 s=1", out_valid, out_src, out_data);
      end
   endtask

   task automatic test_random();
      sync_queue();
      for (int c = 0; c < 400; c++) begin
         in_valid  = N'($urandom_range(0, 7));
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         if ($urandom_range(0, 3) == 0) sel = SELW'($urandom_range(0, 3));
         random_data();
         #1;
         n_cmp++; if (in_ready !== model_ready()) begin
            n_fail++; $display("FAIL rand_ready c=%0d got %b want %b", c, in_ready, model_ready());
         end
         if (out_valid && out_ready) begin
            n_cmp++; if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
               n_fail++; $display("FAIL rand_sb c=%0d got %h queue=%0d", c, out_data, exp_q.size());
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         tick();
         n_cmp++; if (out_valid !== m_valid || out_data !== m_data || out_src !== SELW'(m_src)) begin
            n_fail++; $display("FAIL rand_out c=%0d got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                               c, out_valid, out_data, out_src, m_valid, m_data, m_src);
         end
      end
      n_cmp++; if (exp_q.size() != (m_valid ? 1 : 0)) begin
         n_fail++; $display("FAIL rand_queue_left got %0d want %0d", exp_q.size(), m_valid ? 1 : 0);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_fixed_select();
      test_invalid_select();
      test_round_robin();
      test_rr_skip();
      test_backpressure();
      test_reset_mid_stream();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
